axis_ts_prepend: RTL and testbench
==================================

# axis_ts_prepend

- Sits on the 8-bit AXI-Stream receive path directly downstream of the microsecond timestamp generator.
- Samples the free-running 24-bit timestamp when a frame's first byte arrives.
- Prepends that timestamp as three header bytes ahead of the frame, then passes the frame through unchanged.
- Downstream logic gets per-frame arrival time without a side channel.

## Interface
- `TS_WIDTH`, 24: timestamp width. Fixed at 24; other values are unsupported.
- `HDR_BYTES`, 3: header length in bytes, equal to `TS_WIDTH/8`.
- `clk`  in  1  — sole clock for the block.
- `rst_n`  in  1  — reset, asynchronous assert, active-low.
- `timestamp`  in  24  — free-running µs count from the generator, same clock domain.
- `ts_enable`  in  1  — 1 prepends the header; 0 passes frames unmodified. Sampled only at frame start.
- `s_axis_tdata`  in  8  — input byte.
- `s_axis_tvalid`  in  1  — input byte valid.
- `s_axis_tready`  out  1  — block accepts the input byte.
- `s_axis_tlast`  in  1  — last byte of the frame.
- `s_axis_tuser`  in  1  — error flag, meaningful on the last byte.
- `m_axis_tdata`  out  8  — output byte.
- `m_axis_tvalid`  out  1  — output byte valid.
- `m_axis_tready`  in  1  — downstream accepts the output byte.
- `m_axis_tlast`  out  1  — last byte of the frame.
- `m_axis_tuser`  out  1  — error flag; registered outputs.

## Operation
- FSM states: IDLE, HDR1, HDR2, PASS.
- Reset values: state IDLE, all `m_axis_*` 0, `s_axis_tready` 0.
- IDLE, when `s_axis_tvalid`=1 and the skid buffer can accept:
  - `ts_enable`=1: push `timestamp[23:16]` (live value this cycle) to the output, latch `timestamp[15:0]`, go to HDR1. The input byte is not consumed.
  - `ts_enable`=0: go to PASS without emitting a header.
- HDR1: when accepted by the skid buffer, push the latched `[15:8]` and go to HDR2.
- HDR2: when accepted, push the latched `[7:0]` and go to PASS.
- Header bytes carry `tlast`=0 and `tuser`=0.
- PASS:
  - `s_axis_tready` equals skid-buffer ready.
  - Bytes, `tlast` and `tuser` are forwarded unchanged.
  - When a byte with `tlast`=1 is accepted, go to IDLE.
- `s_axis_tready` is 0 in IDLE, HDR1 and HDR2.
- Single-byte frame: output is 3 header bytes, then that byte with `tlast`=1.
- Timestamp wrap from 0xFFFFFF to 0 is ordinary. No special handling.
- `ts_enable` toggling mid-frame has no effect until the next IDLE.
- Reset mid-frame drops the partial frame. No `tlast` is synthesised and the output is empty after reset.
- Mid-frame timing of `s_axis_tvalid` deassertion is legal. PASS simply waits.

## Timing
- The header timestamp is the `timestamp` value in the cycle the FSM, in IDLE, first sees `s_axis_tvalid`=1 with buffer space available.
- Latency, with `m_axis_tready` held at 1 and first valid seen at cycle T:
  - header byte 0 on `m_axis` at T+1; bytes 1 and 2 at T+2 and T+3;
  - first payload byte accepted at T+3 and visible at T+4.
- Throughput in PASS is one byte per clock. Per-frame overhead is 3 cycles with the header enabled and 1 cycle (IDLE) without.
- Back-to-back frames: the next frame starts in the IDLE cycle after `tlast` is accepted.
- Backpressure: `m_axis_tvalid` stays high and `m_axis_tdata` stays stable until `m_axis_tready`.
- `m_axis_tready`=0 at any point stalls the FSM without losing or duplicating a byte.
- No combinational path from `m_axis_tready` to `s_axis_tready`; the skid buffer breaks it.

## Structure
- Shared MAC package holds `TS_WIDTH`=24, `HDR_BYTES`=3 and the FSM state encoding as named constants.
- Sub-module `axis_skid_buf`: 2-entry, 8+1+1 bits wide.
  - Registered outputs, full throughput.
  - Exposes `in_ready` to the FSM.
  - Asynchronous active-low reset.

## Test plan
- Frame `{0xAA,0xBB,0xCC}` with `timestamp`=0x123456 at first valid and `m_axis_tready`=1 → output 12 34 56 AA BB CC, `tlast` only on CC, header at T+1..T+3.
- `ts_enable`=0 with the same frame → output AA BB CC unchanged; next frame with `ts_enable`=1 gets a header.
- Single-byte frame `0x5D` with `tuser`=1 and `timestamp`=0xFFFFFF → output FF FF FF 5D; `tlast`=1 and `tuser`=1 on 5D only.
- Two back-to-back 64-byte frames with random `m_axis_tready` (50%) → byte-exact output, each header equals the timestamp at its own first-valid cycle, no drops or duplicates.
- Assert `rst_n`=0 mid-payload, release, send a new 4-byte frame → outputs 0 during reset, then a clean 7-byte output with a fresh header.

Source files
------------

// File: rtl/axis_ts_prepend_pkg.sv
// Shared constants and FSM encoding for the timestamp-prepend receive stage.
package axis_ts_prepend_pkg;

    localparam int unsigned TS_WIDTH  = 24;
    localparam int unsigned HDR_BYTES = TS_WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr1 = 2'd1,
        StHdr2 = 2'd2,
        StPass = 2'd3
    } state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered outputs, full throughput, and an
// in_ready that depends only on local state so out_ready never reaches it.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             in_fire;

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees up: drain the skid entry first to keep order.
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_data_q <= in_data;
                end
            end
        end else if (in_fire) begin
            skid_data_q  <= in_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_ts_prepend.sv
// Prepends the 24-bit arrival timestamp (MSB first) as a 3-byte header to each
// AXI-Stream frame, then forwards the frame unchanged.
module axis_ts_prepend
    import axis_ts_prepend_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TS_WIDTH-1:0] timestamp,
    input  logic                ts_enable,
    input  logic [7:0]          s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tuser,
    output logic [7:0]          m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser
);

    state_e      state_q;
    logic [15:0] ts_lo_q;

    logic [7:0]  buf_data;
    logic        buf_last;
    logic        buf_user;
    logic        buf_valid;
    logic        buf_ready;

    always_comb begin
        buf_valid     = 1'b0;
        buf_data      = 8'h00;
        buf_last      = 1'b0;
        buf_user      = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            StIdle: begin
                // MSB goes out straight from the live count; the rest is latched.
                buf_valid = s_axis_tvalid && ts_enable;
                buf_data  = timestamp[23:16];
            end
            StHdr1: begin
                buf_valid = 1'b1;
                buf_data  = ts_lo_q[15:8];
            end
            StHdr2: begin
                buf_valid = 1'b1;
                buf_data  = ts_lo_q[7:0];
            end
            StPass: begin
                s_axis_tready = buf_ready;
                buf_valid     = s_axis_tvalid;
                buf_data      = s_axis_tdata;
                buf_last      = s_axis_tlast;
                buf_user      = s_axis_tuser;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ts_lo_q <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (s_axis_tvalid && buf_ready) begin
                        if (ts_enable) begin
                            ts_lo_q <= timestamp[15:0];
                            state_q <= StHdr1;
                        end else begin
                            state_q <= StPass;
                        end
                    end
                end
                StHdr1: if (buf_ready) state_q <= StHdr2;
                StHdr2: if (buf_ready) state_q <= StPass;
                StPass: if (s_axis_tvalid && buf_ready && s_axis_tlast) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH (10)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({buf_data, buf_last, buf_user}),
        .in_valid  (buf_valid),
        .in_ready  (buf_ready),
        .out_data  ({m_axis_tdata, m_axis_tlast, m_axis_tuser}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_axis_ts_prepend.sv
// Directed bench for axis_ts_prepend with an expected-beat scoreboard.
module tb_axis_ts_prepend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] ts;
    logic        ts_en;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;

    always #5 clk = ~clk;

    axis_ts_prepend dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .timestamp     (ts),
        .ts_enable     (ts_en),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records accepted beats and flags instability under backpressure.
    logic [9:0] obs_beat [0:1023];
    int         obs_cyc  [0:1023];
    int         obs_n = 0;
    int         stab_err = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || {m_tdata, m_tlast, m_tuser} !== prev_beat))
                stab_err <= stab_err + 1;
            prev_stall <= m_tvalid && !m_tready;
            prev_beat  <= {m_tdata, m_tlast, m_tuser};
            if (m_tvalid && m_tready && obs_n < 1024) begin
                obs_beat[obs_n] <= {m_tdata, m_tlast, m_tuser};
                obs_cyc[obs_n]  <= cyc;
                obs_n           <= obs_n + 1;
            end
        end
    end

    int         tests = 0;
    int         fails = 0;
    logic [9:0] exp_q [$];
    logic [7:0] frm [$];
    int         obs_rd = 0;
    int         ts_inc = 0;
    bit         rand_rdy = 1'b0;
    int         base;
    int         t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic consume();
        logic [9:0] e;
        while (obs_rd < obs_n) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("beat{data,last,user}", 32'(obs_beat[obs_rd]), 32'(e));
            end
            obs_rd++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ts = ts + 24'(ts_inc);
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        consume();
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic l, input logic u);
        bit ok;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = s_tready;
            tick();
        end
        check("input_accept", 32'(ok), 32'd1);
    endtask

    // Sends frm (first n_send bytes); header expectation uses ts at the call moment.
    task automatic send_frame(input bit en, input bit user, input int n_send);
        logic last;
        ts_en = en;
        if (en) begin
            exp_q.push_back({ts[23:16], 2'b00});
            exp_q.push_back({ts[15:8], 2'b00});
            exp_q.push_back({ts[7:0], 2'b00});
        end
        for (int i = 0; i < frm.size() && i < n_send; i++) begin
            last = (i == frm.size() - 1);
            exp_q.push_back({frm[i], last, last & user});
            drive_byte(frm[i], last, last & user);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        ts       = 24'h0;
        ts_en    = 1'b1;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({m_tvalid, m_tdata, m_tlast, m_tuser, s_tready}), 32'd0);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        tick();
        tick();

        // Basic frame with a running timestamp, latency T+1..T+4.
        ts_inc = 1;
        ts     = 24'h123456;
        base   = obs_n;
        t0     = cyc;
        frm    = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(1'b1, 1'b0, 3);
        drain();
        check("basic_count", 32'(obs_n - base), 32'd6);
        for (int j = 0; j < 4; j++) check("latency_cycle", 32'(obs_cyc[base + j]), 32'(t0 + 1 + j));

        // Bypass, then a header frame back-to-back.
        base = obs_n;
        frm  = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(1'b0, 1'b0, 3);
        frm  = '{8'h11, 8'h22};
        send_frame(1'b1, 1'b0, 2);
        drain();
        check("bypass_then_hdr_count", 32'(obs_n - base), 32'd8);

        // Single-byte frame at the top of the timestamp range.
        base = obs_n;
        ts   = 24'hFFFFFF;
        frm  = '{8'h5D};
        send_frame(1'b1, 1'b1, 1);
        drain();
        check("single_count", 32'(obs_n - base), 32'd4);

        // Two back-to-back 64-byte frames under random backpressure.
        base     = obs_n;
        rand_rdy = 1'b1;
        ts_inc   = 0;
        ts       = 24'hA1B2C3;
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'($urandom));
        send_frame(1'b1, 1'b0, 64);
        ts = 24'h0D0E0F;
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'($urandom));
        send_frame(1'b1, 1'b1, 64);
        drain();
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        check("random_count", 32'(obs_n - base), 32'd134);
        check("backpressure_stable", 32'(stab_err), 32'd0);

        // Reset mid-payload, then a clean frame.
        ts_inc = 1;
        frm    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        send_frame(1'b1, 1'b0, 4);
        s_tvalid = 1'b1;
        s_tdata  = 8'h35;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midframe_reset_outputs",
              32'({m_tvalid, m_tdata, m_tlast, m_tuser, s_tready}), 32'd0);
        s_tvalid = 1'b0;
        tick();
        exp_q.delete();
        obs_rd = obs_n;
        rst_n  = 1'b1;
        tick();
        base = obs_n;
        ts   = 24'h4B5C6D;
        frm  = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1'b1, 1'b0, 4);
        drain();
        check("post_reset_count", 32'(obs_n - base), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
